// File: rtl/width_down_converter_pkg.sv
// Shared types and default widths for the width down-converter (package wdc_pkg).
package wdc_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam int unsigned WDC_IN_W  = 16;
    localparam int unsigned WDC_OUT_W = 8;

endpackage : wdc_pkg

// File: rtl/width_down_converter_if.sv
// Word-in / slice-out handshake bundle; out_last exists only when WDC_LAST_EN is defined.
interface width_down_converter_if
    import wdc_pkg::*;
#(
    parameter int unsigned IN_W  = WDC_IN_W,
    parameter int unsigned OUT_W = WDC_OUT_W
);
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
`ifdef WDC_LAST_EN
    logic             out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, busy, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, busy, out_last
    );
`else
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, busy
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, busy
    );
`endif

endinterface : width_down_converter_if

// File: rtl/width_down_converter_slice_mux.sv
// Combinational slice selector: picks slice idx of the holding word in LSB- or MSB-first order.
module wdc_slice_mux #(
    parameter int unsigned IN_W      = 16,
    parameter int unsigned OUT_W     = 8,
    parameter bit          MSB_FIRST = 1'b0,
    parameter int unsigned IDX_W     = 1
) (
    input  logic [IN_W-1:0]  hold,
    input  logic [IDX_W-1:0] idx,
    output logic [OUT_W-1:0] out_data
);
    localparam int unsigned RATIO = IN_W / OUT_W;

    logic [IDX_W-1:0] sel;

    always_comb begin
        sel      = MSB_FIRST ? (IDX_W'(RATIO - 1) - idx) : idx;
        out_data = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (sel == IDX_W'(i)) begin
                out_data = hold[i*OUT_W +: OUT_W];
            end
        end
    end

endmodule : wdc_slice_mux

// File: rtl/width_down_converter.sv
// IN_W -> OUT_W gearbox with valid/ready on both sides; optional out_last via WDC_LAST_EN.
module width_down_converter
    import wdc_pkg::*;
#(
    parameter int unsigned IN_W      = WDC_IN_W,
    parameter int unsigned OUT_W     = WDC_OUT_W,
    parameter bit          MSB_FIRST = 1'b0
) (
    input logic                   clk,
    input logic                   rst,
    width_down_converter_if.slave bus
);
    localparam int unsigned RATIO = IN_W / OUT_W;
    localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

    if ((IN_W % OUT_W != 0) || (RATIO < 2)) begin : g_bad_cfg
        $error("width_down_converter: IN_W must be a multiple of OUT_W with ratio >= 2");
    end

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IN_W-1:0]  hold_q, hold_d;

    logic last_c;
    logic out_fire_c;
    logic in_take_c;
    logic load_c;

    // A new word may enter when empty, or on the same edge the final slice leaves.
    assign last_c     = (state_q == ST_FULL) && (idx_q == IDX_LAST);
    assign out_fire_c = (state_q == ST_FULL) && bus.out_ready;
    assign in_take_c  = (state_q == ST_EMPTY) || (last_c && bus.out_ready);
    assign load_c     = bus.in_valid && in_take_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            idx_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        case (state_q)
            ST_EMPTY: begin
                if (load_c) begin
                    hold_d  = bus.in_data;
                    idx_d   = '0;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (load_c) begin
                    hold_d = bus.in_data;
                    idx_d  = '0;
                end else if (out_fire_c) begin
                    if (last_c) begin
                        idx_d   = '0;
                        state_d = ST_EMPTY;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        bus.in_ready  = in_take_c;
        bus.out_valid = (state_q == ST_FULL);
        bus.busy      = (state_q == ST_FULL);
`ifdef WDC_LAST_EN
        bus.out_last  = last_c;
`endif
    end

    wdc_slice_mux #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .MSB_FIRST (MSB_FIRST),
        .IDX_W     (IDX_W)
    ) u_slice_mux (
        .hold     (hold_q),
        .idx      (idx_q),
        .out_data (bus.out_data)
    );

endmodule : width_down_converter
